// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcode constants used by every TL slave and the switch.
package tl_pkg;

   // A-channel request opcodes
   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;

   // D-channel response opcodes
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

endpackage

// File: rtl/uart_pkg.sv
// Register map, STATUS layout and serializer state encodings for the UART blocks.
package uart_pkg;

   // Word offsets decoded from address bits [3:2]
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   // STATUS register bit positions
   localparam int STATUS_FULL_BIT    = 0;
   localparam int STATUS_IDLE_BIT    = 1;
   localparam int STATUS_COUNT_LSB   = 8;
   localparam int STATUS_COUNT_WIDTH = 8;

   // Serializer states, kept as plain constants so older tools can read them
   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count. The read data is combinational from
// the head entry, so a pop consumes the value presented on dout in that cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q;
   logic [PW-1:0]    rdPtr_q;
   logic [CW-1:0]    count_q;
   logic             doPush;
   logic             doPop;

   // Requests against a full or empty FIFO are ignored rather than corrupting state
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: a cleared count makes stale entries unreachable
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= din;
   end

   assign dout  = mem_q[rdPtr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/tl_uart_tx.sv
// TileLink-UL console slave: stores to TXDATA queue bytes, a serializer drains
// them as 8N1 frames, and loads of STATUS let firmware poll the queue.
module tl_uart_tx
   import tl_pkg::*;
   import uart_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SID_WIDTH  = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tl_a_valid,
   output logic                 tl_a_ready,
   input  logic [2:0]           tl_a_opcode,
   input  logic [2:0]           tl_a_param,
   input  logic [2:0]           tl_a_size,
   input  logic [SID_WIDTH-1:0] tl_a_source,
   input  logic [XLEN-1:0]      tl_a_address,
   input  logic [XLEN/8-1:0]    tl_a_mask,
   input  logic [XLEN-1:0]      tl_a_data,
   output logic                 tl_d_valid,
   input  logic                 tl_d_ready,
   output logic [2:0]           tl_d_opcode,
   output logic [1:0]           tl_d_param,
   output logic [2:0]           tl_d_size,
   output logic [SID_WIDTH-1:0] tl_d_source,
   output logic [XLEN-1:0]      tl_d_data,
   output logic                 tl_d_corrupt,
   output logic                 tl_d_denied,
   output logic                 uart_tx
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);

   // FIFO interface
   logic           fifoPush;
   logic           fifoPop;
   logic [7:0]     fifoDout;
   logic           fifoFull;
   logic           fifoEmpty;
   logic [CW-1:0]  fifoCount;

   // Request decode
   logic           aReady;
   logic           aAccept;
   logic           isPut;
   logic           isGet;
   logic [1:0]     regOffset;
   logic           txIdle;
   logic [XLEN-1:0] statusWord;
   logic           unusedBits;

   // Response register
   logic                 dValid_q,  dValid_d;
   logic [2:0]           dOpcode_q, dOpcode_d;
   logic [2:0]           dSize_q,   dSize_d;
   logic [SID_WIDTH-1:0] dSource_q, dSource_d;
   logic [XLEN-1:0]      dData_q,   dData_d;
   logic                 dDenied_q, dDenied_d;

   // Serializer
   logic [1:0]     txState_q, txState_d;
   logic [DW-1:0]  divCnt_q,  divCnt_d;
   logic [2:0]     bitIdx_q,  bitIdx_d;
   logic [7:0]     txByte_q,  txByte_d;
   logic           uartTx_q,  uartTx_d;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifoPush),
      .pop   (fifoPop),
      .din   (tl_a_data[7:0]),
      .dout  (fifoDout),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   // Only one request in flight; a full queue stalls every access, reads included
   assign aReady    = !dValid_q && !fifoFull;
   assign aAccept   = tl_a_valid && aReady;
   assign isPut     = (tl_a_opcode == PUT_FULL) || (tl_a_opcode == PUT_PARTIAL);
   assign isGet     = (tl_a_opcode == GET);
   assign regOffset = tl_a_address[3:2];
   assign txIdle    = fifoEmpty && (txState_q == TX_IDLE);

   // Only offset, byte 0 of data and mask[0] carry meaning for this slave
   assign unusedBits = ^{tl_a_param, tl_a_address[XLEN-1:4], tl_a_address[1:0],
                         tl_a_mask[XLEN/8-1:1], tl_a_data[XLEN-1:8]};

   // Assemble the STATUS word from live FIFO and serializer state
   always_comb begin
      statusWord = '0;
      statusWord[STATUS_FULL_BIT] = fifoFull;
      statusWord[STATUS_IDLE_BIT] = txIdle;
      statusWord[STATUS_COUNT_LSB +: STATUS_COUNT_WIDTH] = STATUS_COUNT_WIDTH'(fifoCount);
   end

   // Decode an accepted beat into a held D response and the optional FIFO push
   always_comb begin
      dValid_d  = dValid_q;
      dOpcode_d = dOpcode_q;
      dSize_d   = dSize_q;
      dSource_d = dSource_q;
      dData_d   = dData_q;
      dDenied_d = dDenied_q;
      fifoPush  = 1'b0;
      if (aAccept) begin
         dValid_d  = 1'b1;
         dSize_d   = tl_a_size;
         dSource_d = tl_a_source;
         dData_d   = '0;
         dDenied_d = 1'b0;
         dOpcode_d = ACCESS_ACK;
         if (isGet) begin
            dOpcode_d = ACCESS_ACK_DATA;
            case (regOffset)
               REG_TXDATA: dData_d   = '0;
               REG_STATUS: dData_d   = statusWord;
               default:    dDenied_d = 1'b1;
            endcase
         end else if (isPut) begin
            case (regOffset)
               REG_TXDATA: fifoPush  = tl_a_mask[0];
               REG_STATUS: dDenied_d = 1'b0;
               default:    dDenied_d = 1'b1;
            endcase
         end else begin
            dDenied_d = 1'b1;
         end
      end else if (dValid_q && tl_d_ready) begin
         dValid_d = 1'b0;
      end
   end

   // Response register; reset drops any pending response
   always_ff @(posedge clk) begin
      if (reset) begin
         dValid_q  <= 1'b0;
         dOpcode_q <= '0;
         dSize_q   <= '0;
         dSource_q <= '0;
         dData_q   <= '0;
         dDenied_q <= 1'b0;
      end else begin
         dValid_q  <= dValid_d;
         dOpcode_q <= dOpcode_d;
         dSize_q   <= dSize_d;
         dSource_q <= dSource_d;
         dData_q   <= dData_d;
         dDenied_q <= dDenied_d;
      end
   end

   // Serializer: each state holds for CLK_DIV clocks; STOP chains straight into START
   always_comb begin
      txState_d = txState_q;
      divCnt_d  = divCnt_q;
      bitIdx_d  = bitIdx_q;
      txByte_d  = txByte_q;
      uartTx_d  = uartTx_q;
      fifoPop   = 1'b0;
      case (txState_q)
         TX_IDLE: begin
            uartTx_d = 1'b1;
            if (!fifoEmpty) begin
               fifoPop   = 1'b1;
               txByte_d  = fifoDout;
               txState_d = TX_START;
               divCnt_d  = DIV_LAST;
               uartTx_d  = 1'b0;
            end
         end
         TX_START: begin
            if (divCnt_q == '0) begin
               txState_d = TX_DATA;
               divCnt_d  = DIV_LAST;
               bitIdx_d  = 3'd0;
               uartTx_d  = txByte_q[0];
            end else begin
               divCnt_d = divCnt_q - 1'b1;
            end
         end
         TX_DATA: begin
            if (divCnt_q == '0) begin
               divCnt_d = DIV_LAST;
               if (bitIdx_q == 3'd7) begin
                  txState_d = TX_STOP;
                  uartTx_d  = 1'b1;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
                  uartTx_d = txByte_q[bitIdx_q + 1'b1];
               end
            end else begin
               divCnt_d = divCnt_q - 1'b1;
            end
         end
         TX_STOP: begin
            if (divCnt_q == '0) begin
               if (!fifoEmpty) begin
                  fifoPop   = 1'b1;
                  txByte_d  = fifoDout;
                  txState_d = TX_START;
                  divCnt_d  = DIV_LAST;
                  uartTx_d  = 1'b0;
               end else begin
                  txState_d = TX_IDLE;
                  uartTx_d  = 1'b1;
               end
            end else begin
               divCnt_d = divCnt_q - 1'b1;
            end
         end
         default: begin
            txState_d = TX_IDLE;
            uartTx_d  = 1'b1;
         end
      endcase
   end

   // Serializer registers; reset aborts any frame and returns the line to idle-high
   always_ff @(posedge clk) begin
      if (reset) begin
         txState_q <= TX_IDLE;
         divCnt_q  <= '0;
         bitIdx_q  <= '0;
         txByte_q  <= '0;
         uartTx_q  <= 1'b1;
      end else begin
         txState_q <= txState_d;
         divCnt_q  <= divCnt_d;
         bitIdx_q  <= bitIdx_d;
         txByte_q  <= txByte_d;
         uartTx_q  <= uartTx_d;
      end
   end

   assign tl_a_ready   = aReady;
   assign tl_d_valid   = dValid_q;
   assign tl_d_opcode  = dOpcode_q;
   assign tl_d_param   = 2'b00;
   assign tl_d_size    = dSize_q;
   assign tl_d_source  = dSource_q;
   assign tl_d_data    = dData_q;
   assign tl_d_corrupt = 1'b0;
   assign tl_d_denied  = dDenied_q;
   assign uart_tx      = uartTx_q;

endmodule
